// File: rtl/traffic_lamp_monitor.sv
// Safety stage between the traffic_light controller and the lamp drivers: forwards lamp requests
// and latches a flashing-amber fail-safe on persistent faults. Optional macro: TLM_GREEN_WDOG_EN.
module traffic_lamp_monitor #(
  parameter int BAD_CYCLES     = 2,
  parameter int RECOVER_CYCLES = 8,
  parameter int FLASH_HALF     = 4,
  parameter int MAX_GREEN      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light_A,
  input  logic [2:0] light_B,
  input  logic       fault_clr,
  output logic [2:0] lamp_A,
  output logic [2:0] lamp_B,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [1:0] debug_state
);

  localparam logic [1:0] ST_PASS    = 2'd0;
  localparam logic [1:0] ST_SUSPECT = 2'd1;
  localparam logic [1:0] ST_FLASH   = 2'd2;
  localparam logic [1:0] ST_RECOVER = 2'd3;

  localparam logic [2:0] LAMP_GREEN = 3'b001;
  localparam logic [2:0] LAMP_AMBER = 3'b010;
  localparam logic [2:0] LAMP_RED   = 3'b100;
  localparam logic [2:0] LAMP_OFF   = 3'b000;

  localparam int BW = $clog2(BAD_CYCLES + 1);
  localparam int RW = $clog2(RECOVER_CYCLES + 1);
  localparam int FW = $clog2(FLASH_HALF + 1);

  if (BAD_CYCLES < 1 || RECOVER_CYCLES < 1 || FLASH_HALF < 1 || MAX_GREEN < 1) begin : g_param_check
    $error("traffic_lamp_monitor: all timing parameters must be >= 1");
  end

  logic [1:0]    state;
  logic [BW-1:0] bad_cnt;
  logic [RW-1:0] rec_cnt;
  logic [FW-1:0] flash_cnt;
  logic          flash_off;
  logic [2:0]    cause_acc;

  logic          enc_err;
  logic          conflict;
  logic          wdog;
  logic [2:0]    cause;
  logic          bad;
  logic [BW-1:0] bad_next;
  logic          bad_trip;

`ifdef TLM_GREEN_WDOG_EN
  localparam int GW = $clog2(MAX_GREEN + 1);
  logic [GW-1:0] gcnt_a;
  logic [GW-1:0] gcnt_b;

  // Counters track the raw inputs in every state so the watchdog sees true green run length.
  always_ff @(posedge clk) begin
    if (rst) begin
      gcnt_a <= '0;
      gcnt_b <= '0;
    end else begin
      if (light_A != LAMP_GREEN)          gcnt_a <= '0;
      else if (gcnt_a != GW'(MAX_GREEN))  gcnt_a <= gcnt_a + 1'b1;
      if (light_B != LAMP_GREEN)          gcnt_b <= '0;
      else if (gcnt_b != GW'(MAX_GREEN))  gcnt_b <= gcnt_b + 1'b1;
    end
  end

  assign wdog = ((light_A == LAMP_GREEN) && (gcnt_a == GW'(MAX_GREEN))) ||
                ((light_B == LAMP_GREEN) && (gcnt_b == GW'(MAX_GREEN)));
`else
  assign wdog = 1'b0;
`endif

  assign enc_err  = !$onehot(light_A) || !$onehot(light_B);
  assign conflict = (light_A != LAMP_RED) && (light_B != LAMP_RED);
  assign cause    = {wdog, conflict, enc_err};
  assign bad      = |cause;

  assign bad_next = (bad_cnt == BW'(BAD_CYCLES)) ? bad_cnt : bad_cnt + 1'b1;
  assign bad_trip = (bad_next == BW'(BAD_CYCLES));

  assign debug_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_PASS;
      lamp_A     <= LAMP_RED;
      lamp_B     <= LAMP_RED;
      fault      <= 1'b0;
      fault_code <= 3'b000;
      bad_cnt    <= '0;
      rec_cnt    <= '0;
      flash_cnt  <= '0;
      flash_off  <= 1'b0;
      cause_acc  <= 3'b000;
    end else begin
      case (state)
        ST_PASS: begin
          if (bad) begin
            cause_acc <= cause;
            if (BAD_CYCLES == 1) begin
              state      <= ST_FLASH;
              fault      <= 1'b1;
              fault_code <= cause;
              flash_cnt  <= '0;
              flash_off  <= 1'b0;
              lamp_A     <= LAMP_AMBER;
              lamp_B     <= LAMP_AMBER;
            end else begin
              state   <= ST_SUSPECT;
              bad_cnt <= BW'(1);
              lamp_A  <= LAMP_RED;
              lamp_B  <= LAMP_RED;
            end
          end else begin
            cause_acc <= 3'b000;
            lamp_A    <= light_A;
            lamp_B    <= light_B;
          end
        end

        ST_SUSPECT: begin
          if (bad) begin
            bad_cnt   <= bad_next;
            cause_acc <= cause_acc | cause;
            if (bad_trip) begin
              state      <= ST_FLASH;
              fault      <= 1'b1;
              fault_code <= cause_acc | cause;
              flash_cnt  <= '0;
              flash_off  <= 1'b0;
              lamp_A     <= LAMP_AMBER;
              lamp_B     <= LAMP_AMBER;
            end else begin
              lamp_A <= LAMP_RED;
              lamp_B <= LAMP_RED;
            end
          end else begin
            state     <= ST_PASS;
            bad_cnt   <= '0;
            cause_acc <= 3'b000;
            lamp_A    <= light_A;
            lamp_B    <= light_B;
          end
        end

        ST_FLASH: begin
          if (fault_clr) begin
            state   <= ST_RECOVER;
            rec_cnt <= '0;
            lamp_A  <= LAMP_RED;
            lamp_B  <= LAMP_RED;
          end else if (flash_cnt == FW'(FLASH_HALF - 1)) begin
            // End of a half period: swap between amber and dark.
            flash_cnt <= '0;
            flash_off <= ~flash_off;
            lamp_A    <= flash_off ? LAMP_AMBER : LAMP_OFF;
            lamp_B    <= flash_off ? LAMP_AMBER : LAMP_OFF;
          end else begin
            flash_cnt <= flash_cnt + 1'b1;
            lamp_A    <= flash_off ? LAMP_OFF : LAMP_AMBER;
            lamp_B    <= flash_off ? LAMP_OFF : LAMP_AMBER;
          end
        end

        ST_RECOVER: begin
          lamp_A <= LAMP_RED;
          lamp_B <= LAMP_RED;
          if (bad) begin
            rec_cnt <= '0;
          end else if (rec_cnt == RW'(RECOVER_CYCLES - 1)) begin
            // Lamps stay red on this edge; inputs pass through from the next one.
            state      <= ST_PASS;
            fault      <= 1'b0;
            fault_code <= 3'b000;
            rec_cnt    <= '0;
            bad_cnt    <= '0;
            cause_acc  <= 3'b000;
          end else begin
            rec_cnt <= rec_cnt + 1'b1;
          end
        end

        default: begin
          state  <= ST_PASS;
          lamp_A <= LAMP_RED;
          lamp_B <= LAMP_RED;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_lamp_monitor.sv
// Bench for traffic_lamp_monitor: vector table plus hand-built flash/recover/watchdog sequences,
// checked through an expected-value queue one cycle after each stimulus.
module tb_traffic_lamp_monitor;

  localparam logic [2:0] G  = 3'b001;
  localparam logic [2:0] AM = 3'b010;
  localparam logic [2:0] R  = 3'b100;
  localparam logic [2:0] OF = 3'b000;

  logic       clk;
  logic       rst;
  logic [2:0] light_a;
  logic [2:0] light_b;
  logic       fault_clr;
  logic [2:0] lamp_a;
  logic [2:0] lamp_b;
  logic       fault;
  logic [2:0] fault_code;
  logic [1:0] debug_state;

  int errors = 0;
  int checks = 0;

  logic [9:0] exp_q[$];
  string      name_q[$];

  typedef struct packed {
    logic       rst;
    logic [2:0] a;
    logic [2:0] b;
    logic       clr;
    logic [2:0] ea;
    logic [2:0] eb;
    logic       ef;
    logic [2:0] ec;
  } vec_t;

  vec_t vecs[15];

  traffic_lamp_monitor dut (
    .clk        (clk),
    .rst        (rst),
    .light_A    (light_a),
    .light_B    (light_b),
    .fault_clr  (fault_clr),
    .lamp_A     (lamp_a),
    .lamp_B     (lamp_b),
    .fault      (fault),
    .fault_code (fault_code),
    .debug_state(debug_state)
  );

  // clock / reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [9:0] pack(input logic [2:0] la, input logic [2:0] lb,
                                      input logic f, input logic [2:0] c);
    return {la, lb, f, c};
  endfunction

  task automatic check_out();
    logic [9:0] got;
    logic [9:0] exp;
    string      nm;
    got = {lamp_a, lamp_b, fault, fault_code};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %b with no expected entry", got);
    end else begin
      exp = exp_q.pop_front();
      nm  = name_q.pop_front();
      if (got !== exp) begin
        errors++;
        $display("FAIL %s: got lamp_A=%b lamp_B=%b fault=%b code=%b, want lamp_A=%b lamp_B=%b fault=%b code=%b",
                 nm, got[9:7], got[6:4], got[3], got[2:0], exp[9:7], exp[6:4], exp[3], exp[2:0]);
      end
    end
  endtask

  task automatic step(input logic r, input logic [2:0] a, input logic [2:0] b, input logic c,
                      input logic [9:0] exp, input string nm);
    @(negedge clk);
    rst       = r;
    light_a   = a;
    light_b   = b;
    fault_clr = c;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    rst       = 1'b1;
    light_a   = R;
    light_b   = R;
    fault_clr = 1'b0;

    // rst, A, B, clr, exp A, exp B, fault, code
    vecs[0]  = '{1'b1, G,      R,  1'b0, R,  R,  1'b0, 3'b000};
    vecs[1]  = '{1'b0, G,      R,  1'b0, G,  R,  1'b0, 3'b000};
    vecs[2]  = '{1'b0, AM,     R,  1'b0, AM, R,  1'b0, 3'b000};
    vecs[3]  = '{1'b0, R,      R,  1'b0, R,  R,  1'b0, 3'b000};
    vecs[4]  = '{1'b0, R,      G,  1'b0, R,  G,  1'b0, 3'b000};
    vecs[5]  = '{1'b0, R,      AM, 1'b0, R,  AM, 1'b0, 3'b000};
    vecs[6]  = '{1'b0, R,      R,  1'b0, R,  R,  1'b0, 3'b000};
    vecs[7]  = '{1'b0, G,      G,  1'b0, R,  R,  1'b0, 3'b000};
    vecs[8]  = '{1'b0, G,      R,  1'b0, G,  R,  1'b0, 3'b000};
    vecs[9]  = '{1'b0, OF,     R,  1'b0, R,  R,  1'b0, 3'b000};
    vecs[10] = '{1'b0, G,      R,  1'b1, G,  R,  1'b0, 3'b000};
    vecs[11] = '{1'b0, 3'b011, R,  1'b0, R,  R,  1'b0, 3'b000};
    vecs[12] = '{1'b0, R,      R,  1'b0, R,  R,  1'b0, 3'b000};
    vecs[13] = '{1'b0, G,      G,  1'b0, R,  R,  1'b0, 3'b000};
    vecs[14] = '{1'b0, G,      G,  1'b0, AM, AM, 1'b1, 3'b010};

    for (int i = 0; i < 15; i++) begin
      step(vecs[i].rst, vecs[i].a, vecs[i].b, vecs[i].clr,
           pack(vecs[i].ea, vecs[i].eb, vecs[i].ef, vecs[i].ec), $sformatf("vec%0d", i));
    end

    // flashing: vec14 showed phase 0; walk the rest of two full periods
    for (int i = 1; i < 16; i++) begin
      step(1'b0, R, R, 1'b0, pack(((i % 8) < 4) ? AM : OF, ((i % 8) < 4) ? AM : OF, 1'b1, 3'b010),
           $sformatf("flash%0d", i));
    end

    step(1'b0, R, R, 1'b1, pack(R, R, 1'b1, 3'b010), "clr_enter_recover");
    for (int i = 0; i < 5; i++)
      step(1'b0, (i % 2) ? G : R, (i % 2) ? R : G, 1'b0, pack(R, R, 1'b1, 3'b010),
           $sformatf("recover_a%0d", i));
    step(1'b0, G, G, 1'b0, pack(R, R, 1'b1, 3'b010), "recover_bad_restart");
    for (int i = 0; i < 7; i++)
      step(1'b0, (i % 2) ? G : R, (i % 2) ? R : G, 1'b0, pack(R, R, 1'b1, 3'b010),
           $sformatf("recover_b%0d", i));
    step(1'b0, R, G, 1'b0, pack(R, R, 1'b0, 3'b000), "recover_exit");
    step(1'b0, G, R, 1'b0, pack(G, R, 1'b0, 3'b000), "pass_follow");

    // encoding fault then reset mid-flash
    step(1'b0, 3'b011, R, 1'b0, pack(R, R, 1'b0, 3'b000), "enc_first");
    step(1'b0, 3'b011, R, 1'b0, pack(AM, AM, 1'b1, 3'b001), "enc_trip");
    step(1'b0, R, R, 1'b0, pack(AM, AM, 1'b1, 3'b001), "enc_flash");
    step(1'b1, G, R, 1'b1, pack(R, R, 1'b0, 3'b000), "rst_mid_flash");
    step(1'b0, G, R, 1'b0, pack(G, R, 1'b0, 3'b000), "after_rst");

    // long green on A
    step(1'b0, R, R, 1'b0, pack(R, R, 1'b0, 3'b000), "green_pre");
    for (int i = 1; i <= 10; i++) begin
`ifdef TLM_GREEN_WDOG_EN
      if (i <= 8)      step(1'b0, G, R, 1'b0, pack(G, R, 1'b0, 3'b000), $sformatf("green%0d", i));
      else if (i == 9) step(1'b0, G, R, 1'b0, pack(R, R, 1'b0, 3'b000), "green_wdog_first");
      else             step(1'b0, G, R, 1'b0, pack(AM, AM, 1'b1, 3'b100), "green_wdog_trip");
`else
      step(1'b0, G, R, 1'b0, pack(G, R, 1'b0, 3'b000), $sformatf("green%0d", i));
`endif
    end

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d entries remain, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
